// File: rtl/sf_tester_fsm_pkg.sv
// Shared types and pattern constants for the SF tester FSM and its pattern engine.
package sf_tester_fsm_pkg;

  localparam logic [7:0] c_tester_pattern_a_start = 8'h00;
  localparam logic [7:0] c_tester_pattern_a_incr  = 8'h01;
  localparam logic [7:0] c_tester_pattern_b_start = 8'h08;
  localparam logic [7:0] c_tester_pattern_b_incr  = 8'h07;
  localparam logic [7:0] c_tester_pattern_c_start = 8'h10;
  localparam logic [7:0] c_tester_pattern_c_incr  = 8'h0F;
  localparam logic [7:0] c_tester_pattern_d_start = 8'h18;
  localparam logic [7:0] c_tester_pattern_d_incr  = 8'h17;

  typedef enum logic [1:0] {PAT_A, PAT_B, PAT_C, PAT_D} t_pattern_sel;

  typedef enum logic [1:0] {ST_PE_IDLE, ST_PE_GEN, ST_PE_CHK} t_pattern_engine_state;

  function automatic logic [7:0] fn_pattern_startval(input t_pattern_sel sel);
    case (sel)
      PAT_A:   return c_tester_pattern_a_start;
      PAT_B:   return c_tester_pattern_b_start;
      PAT_C:   return c_tester_pattern_c_start;
      default: return c_tester_pattern_d_start;
    endcase
  endfunction

  function automatic logic [7:0] fn_pattern_incrval(input t_pattern_sel sel);
    case (sel)
      PAT_A:   return c_tester_pattern_a_incr;
      PAT_B:   return c_tester_pattern_b_incr;
      PAT_C:   return c_tester_pattern_c_incr;
      default: return c_tester_pattern_d_incr;
    endcase
  endfunction

endpackage

// File: rtl/sf_tester_pattern_seq.sv
// 8-bit load/advance accumulator producing the current pattern byte (mod-256 wrap).
module sf_tester_pattern_seq (
  input  logic       i_clk_20mhz,
  input  logic       i_rst_20mhz_n,
  input  logic       i_load,
  input  logic [7:0] i_startval,
  input  logic       i_advance,
  input  logic [7:0] i_incr,
  output logic [7:0] o_value
);

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rst_20mhz_n)
      o_value <= 8'h00;
    else if (i_load)
      o_value <= i_startval;
    else if (i_advance)
      o_value <= o_value + i_incr;
  end

endmodule

// File: rtl/sf_tester_pattern_engine.sv
// Pattern generator/checker between the tester FSM and the serial-flash driver:
// GEN streams the selected byte pattern, CHK compares read-back bytes against it.
module sf_tester_pattern_engine
  import sf_tester_fsm_pkg::*;
#(
  parameter int unsigned PER_ITER_BYTES = 1048576,
  parameter int          CNT_W          = 32
) (
  input  logic             i_clk_20mhz,
  input  logic             i_rst_20mhz_n,
  input  logic [1:0]       i_pattern_sel,
  input  logic             i_gen_start,
  input  logic             i_chk_start,
  input  logic             i_abort,
  output logic [7:0]       o_tx_byte,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_rx_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_first_err_offset,
  output logic [CNT_W-1:0] o_byte_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PER_ITER_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  t_pattern_engine_state state;
  t_pattern_sel          pat_q;
  t_pattern_sel          pat_sel_in;
  logic                  seq_load;
  logic                  seq_advance;
  logic                  tx_fire;
  logic                  rx_fire;
  logic                  last_byte;
  logic                  mismatch;
  logic [7:0]            seq_value;
  logic [7:0]            load_val;
  logic [7:0]            incr_val;

  assign pat_sel_in  = t_pattern_sel'(i_pattern_sel);
  assign seq_load    = (state == ST_PE_IDLE) && (i_gen_start || i_chk_start);
  assign tx_fire     = (state == ST_PE_GEN) && o_tx_valid && i_tx_ready && !i_abort;
  assign rx_fire     = (state == ST_PE_CHK) && i_rx_valid && !i_abort;
  assign seq_advance = tx_fire || rx_fire;
  assign last_byte   = (o_byte_count == LAST_IDX);
  assign mismatch    = (i_rx_byte != seq_value);
  assign load_val    = fn_pattern_startval(pat_sel_in);
  assign incr_val    = fn_pattern_incrval(pat_q);

  // The accumulator is the single pattern source; in GEN its value is the tx byte.
  sf_tester_pattern_seq u_seq (
    .i_clk_20mhz   (i_clk_20mhz),
    .i_rst_20mhz_n (i_rst_20mhz_n),
    .i_load        (seq_load),
    .i_startval    (load_val),
    .i_advance     (seq_advance),
    .i_incr        (incr_val),
    .o_value       (seq_value)
  );

  assign o_tx_byte = seq_value;

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rst_20mhz_n) begin
      state              <= ST_PE_IDLE;
      pat_q              <= PAT_A;
      o_tx_valid         <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_pass             <= 1'b0;
      o_err_count        <= '0;
      o_first_err_offset <= '1;
      o_byte_count       <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_PE_IDLE: begin
          if (i_gen_start) begin
            state        <= ST_PE_GEN;
            pat_q        <= pat_sel_in;
            o_byte_count <= '0;
            o_tx_valid   <= 1'b1;
            o_busy       <= 1'b1;
          end else if (i_chk_start) begin
            state              <= ST_PE_CHK;
            pat_q              <= pat_sel_in;
            o_byte_count       <= '0;
            o_err_count        <= '0;
            o_first_err_offset <= '1;
            o_pass             <= 1'b0;
            o_busy             <= 1'b1;
          end
        end
        ST_PE_GEN: begin
          if (i_abort) begin
            state      <= ST_PE_IDLE;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
          end else if (tx_fire) begin
            o_byte_count <= o_byte_count + CNT_ONE;
            if (last_byte) begin
              state      <= ST_PE_IDLE;
              o_tx_valid <= 1'b0;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
            end
          end
        end
        ST_PE_CHK: begin
          if (i_abort) begin
            state  <= ST_PE_IDLE;
            o_busy <= 1'b0;
          end else if (rx_fire) begin
            o_byte_count <= o_byte_count + CNT_ONE;
            if (mismatch) begin
              if (o_err_count != '1)
                o_err_count <= o_err_count + CNT_ONE;
              if (o_err_count == '0)
                o_first_err_offset <= o_byte_count;
            end
            // Final verdict must include the compare happening on this same edge.
            if (last_byte) begin
              state  <= ST_PE_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              o_pass <= (o_err_count == '0) && !mismatch;
            end
          end
        end
        default: state <= ST_PE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sf_tester_pattern_engine.sv
// Directed bench for sf_tester_pattern_engine: a 16-byte instance for most runs, a 300-byte one for wrap.
module tb_sf_tester_pattern_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        gen_start, chk_start, abort, tx_ready, rx_valid;
  logic [7:0]  rx_byte;
  logic        l_gen_start, l_chk_start, l_abort, l_tx_ready;

  logic [7:0]  tx_byte, l_tx_byte;
  logic        tx_valid, busy, done, pass;
  logic        l_tx_valid, l_busy, l_done, l_pass;
  logic [31:0] err, first, count;
  logic [31:0] l_err, l_first, l_count;

  int checks   = 0;
  int failures = 0;

  always #25 clk = ~clk;

  sf_tester_pattern_engine #(.PER_ITER_BYTES(16), .CNT_W(32)) dut16 (
    .i_clk_20mhz(clk), .i_rst_20mhz_n(rst_n), .i_pattern_sel(sel),
    .i_gen_start(gen_start), .i_chk_start(chk_start), .i_abort(abort),
    .o_tx_byte(tx_byte), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err), .o_first_err_offset(first), .o_byte_count(count)
  );

  sf_tester_pattern_engine #(.PER_ITER_BYTES(300), .CNT_W(32)) dut300 (
    .i_clk_20mhz(clk), .i_rst_20mhz_n(rst_n), .i_pattern_sel(sel),
    .i_gen_start(l_gen_start), .i_chk_start(l_chk_start), .i_abort(l_abort),
    .o_tx_byte(l_tx_byte), .o_tx_valid(l_tx_valid), .i_tx_ready(l_tx_ready),
    .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_busy(l_busy), .o_done(l_done), .o_pass(l_pass),
    .o_err_count(l_err), .o_first_err_offset(l_first), .o_byte_count(l_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pattern: startval + k*incr, mod 256.
  function automatic logic [7:0] pat_val(input int p, input int k);
    int s, i;
    case (p)
      0:       begin s = 8'h00; i = 8'h01; end
      1:       begin s = 8'h08; i = 8'h07; end
      2:       begin s = 8'h10; i = 8'h0F; end
      default: begin s = 8'h18; i = 8'h17; end
    endcase
    return 8'((s + i * k) % 256);
  endfunction

  initial begin
    int   idx;
    int   dones;
    bit   stalled;
    bit   seen_done;
    logic [7:0] held;

    rst_n = 1'b0; sel = 2'd0; gen_start = 1'b0; chk_start = 1'b0; abort = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    l_gen_start = 1'b0; l_chk_start = 1'b0; l_abort = 1'b0; l_tx_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    check_eq("rst_tx_byte", 32'(tx_byte), 32'h0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_pass", 32'(pass), 32'h0);
    check_eq("rst_err", err, 32'h0);
    check_eq("rst_first", first, 32'hFFFF_FFFF);
    check_eq("rst_count", count, 32'h0);

    // GEN pattern A, always ready
    sel = 2'd0; tx_ready = 1'b1; gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    check_eq("gen_a_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 16; k++) begin
      check_eq("gen_a_byte", 32'(tx_byte), 32'(pat_val(0, k)));
      check_eq("gen_a_valid", 32'(tx_valid), 32'h1);
      tick();
    end
    check_eq("gen_a_done", 32'(done), 32'h1);
    check_eq("gen_a_valid_end", 32'(tx_valid), 32'h0);
    check_eq("gen_a_busy_end", 32'(busy), 32'h0);
    check_eq("gen_a_count", count, 32'd16);
    tick();
    check_eq("gen_a_done_pulse", 32'(done), 32'h0);

    // GEN pattern D with ready toggling
    sel = 2'd3; tx_ready = 1'b0; gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    idx = 0; stalled = 1'b0; seen_done = 1'b0; held = 8'h00;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (stalled) check_eq("gen_d_stall", 32'(tx_byte), 32'(held));
        tx_ready = c[0];
        if (tx_valid && tx_ready) begin
          check_eq("gen_d_byte", 32'(tx_byte), 32'(pat_val(3, idx)));
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = tx_valid;
          held    = tx_byte;
        end
        tick();
      end
    end
    check_eq("gen_d_done_seen", 32'(seen_done), 32'h1);
    check_eq("gen_d_accepted", 32'(idx), 32'd16);
    check_eq("gen_d_count", count, 32'd16);
    tx_ready = 1'b1;

    // Reset in the middle of a GEN run
    sel = 2'd0; gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_eq("rst_mid_byte7", 32'(tx_byte), 32'h07);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst_mid_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_mid_busy", 32'(busy), 32'h0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dones++;
      tick();
    end
    check_eq("rst_mid_no_done", 32'(dones), 32'h0);
    sel = 2'd1; gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    check_eq("restart_byte", 32'(tx_byte), 32'h08);
    check_eq("restart_valid", 32'(tx_valid), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("restart_abort_busy", 32'(busy), 32'h0);

    // Simultaneous starts: GEN wins; abort after three bytes
    sel = 2'd2; gen_start = 1'b1; chk_start = 1'b1;
    tick();
    gen_start = 1'b0; chk_start = 1'b0;
    check_eq("both_gen_valid", 32'(tx_valid), 32'h1);
    check_eq("both_gen_byte", 32'(tx_byte), 32'h10);
    tick(); tick(); tick();
    check_eq("abort_pre_count", count, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'h0);
    check_eq("abort_valid", 32'(tx_valid), 32'h0);
    check_eq("abort_count", count, 32'd3);
    check_eq("abort_no_done", 32'(done), 32'h0);
    tick();
    check_eq("abort_idle_count", count, 32'd3);

    // CHK pattern B with offsets 5 and 9 corrupted
    sel = 2'd1; chk_start = 1'b1;
    tick();
    chk_start = 1'b0;
    check_eq("chk_b_busy", 32'(busy), 32'h1);
    check_eq("chk_b_first_init", first, 32'hFFFF_FFFF);
    for (int k = 0; k < 16; k++) begin
      rx_valid = 1'b1;
      rx_byte  = pat_val(1, k) ^ ((k == 5 || k == 9) ? 8'hFF : 8'h00);
      tick();
      if (k == 5) begin
        check_eq("chk_b_err_at5", err, 32'd1);
        check_eq("chk_b_first_at5", first, 32'd5);
      end
    end
    rx_valid = 1'b0;
    check_eq("chk_b_done", 32'(done), 32'h1);
    check_eq("chk_b_err", err, 32'd2);
    check_eq("chk_b_first", first, 32'd5);
    check_eq("chk_b_pass", 32'(pass), 32'h0);
    check_eq("chk_b_count", count, 32'd16);
    check_eq("chk_b_busy_end", 32'(busy), 32'h0);

    // Back-to-back CHK of a clean pattern A stream, started in the done cycle
    sel = 2'd0; chk_start = 1'b1;
    tick();
    chk_start = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'h1);
    check_eq("b2b_err_clr", err, 32'h0);
    check_eq("b2b_first_clr", first, 32'hFFFF_FFFF);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        rx_valid = 1'b0;
        tick();
      end
      rx_valid = 1'b1;
      rx_byte  = pat_val(0, k);
      tick();
    end
    rx_valid = 1'b0;
    check_eq("chk_a_done", 32'(done), 32'h1);
    check_eq("chk_a_pass", 32'(pass), 32'h1);
    check_eq("chk_a_err", err, 32'h0);
    check_eq("chk_a_count", count, 32'd16);

    // 300-byte CHK pattern C on the second instance (wraps at byte 256)
    sel = 2'd2; l_chk_start = 1'b1;
    tick();
    l_chk_start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      rx_valid = 1'b1;
      rx_byte  = pat_val(2, k);
      tick();
    end
    rx_valid = 1'b0;
    check_eq("chk_c_done", 32'(l_done), 32'h1);
    check_eq("chk_c_pass", 32'(l_pass), 32'h1);
    check_eq("chk_c_err", l_err, 32'h0);
    check_eq("chk_c_first", l_first, 32'hFFFF_FFFF);
    check_eq("chk_c_count", l_count, 32'd300);
    check_eq("idle_rx_ignored", count, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
